// File: rtl/clk_div_6.sv
// clk_div_6: registered divide-by-COEFFICIENT clock (low floor(N/2), high N-floor(N/2)); ports i_clk, i_reset (sync active-high), o_div_clk
module clk_div_6 #(
    parameter int COEFFICIENT = 6,
    parameter int CNT_WIDTH   = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_div_clk
);
    generate
        if (COEFFICIENT < 2 || (2 ** CNT_WIDTH) < COEFFICIENT) begin : g_bad_cfg
            $error("clk_div_6: COEFFICIENT must be >= 2 and fit in CNT_WIDTH bits");
        end
    endgenerate
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(COEFFICIENT - 1);
    localparam logic [CNT_WIDTH-1:0] RISE = CNT_WIDTH'(COEFFICIENT / 2 - 1);
    logic [CNT_WIDTH-1:0] cnt;
    logic                 div_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt   <= '0;
            div_q <= 1'b0;
        end else begin
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            div_q <= (cnt == RISE) ? 1'b1 : (cnt == LAST) ? 1'b0 : div_q;
        end
    end
    assign o_div_clk = div_q;
endmodule

// File: tb/tb_clk_div_6.sv
// tb_clk_div_6: checks divide-by-6/24/5/2 instances against an edge-count reference model
module tb_clk_div_6;
    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic d6, d24, d5, d2;
    int   k = 0;
    int   errors = 0;
    int   checks = 0;

    always #10 clk = ~clk;

    clk_div_6 #(.COEFFICIENT(6),  .CNT_WIDTH(3)) u6  (.i_clk(clk), .i_reset(i_reset), .o_div_clk(d6));
    clk_div_6 #(.COEFFICIENT(24), .CNT_WIDTH(5)) u24 (.i_clk(clk), .i_reset(i_reset), .o_div_clk(d24));
    clk_div_6 #(.COEFFICIENT(5),  .CNT_WIDTH(3)) u5  (.i_clk(clk), .i_reset(i_reset), .o_div_clk(d5));
    clk_div_6 #(.COEFFICIENT(2),  .CNT_WIDTH(1)) u2  (.i_clk(clk), .i_reset(i_reset), .o_div_clk(d2));

    // k = edges since the last reset edge; output is high during the last N-floor(N/2) of each N
    function automatic logic model(input int n);
        return (k % n) >= (n / 2);
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d got=%b expected=%b", tag, k, got, exp);
        end
    endtask

    task automatic step(input logic r);
        i_reset = r;
        @(posedge clk);
        #1;
        k = r ? 0 : k + 1;
        chk("div6", d6, model(6));
        chk("div24", d24, model(24));
        chk("div5", d5, model(5));
        chk("div2", d2, model(2));
    endtask

    initial begin
        int rises;
        int run_len;
        int exp_rises;
        logic prev;
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 120; i++) step(1'b0);
        for (int i = 0; i < 6 && (k % 6) != 4; i++) step(1'b0);
        chk("mid_before_rst", d6, 1'b1);
        step(1'b1);
        chk("mid_rst_low", d6, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            chk("mid_relow", d6, 1'b0);
        end
        step(1'b0);
        chk("mid_rehigh", d6, 1'b1);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 24) == 0);
        step(1'b1);
        rises = 0;
        run_len = 1;
        prev = d6;
        for (int i = 0; i < 10000; i++) begin
            step(1'b0);
            if (d6 !== prev) begin
                chk("phase_width", (run_len == 3), 1'b1);
                if (d6 === 1'b1) rises++;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev = d6;
        end
        exp_rises = (10000 - 3) / 6 + 1;
        checks++;
        assert (rises == exp_rises) else begin
            errors++;
            $error("FAIL long_run_rises got=%0d expected=%0d", rises, exp_rises);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
